booth_datapath: RTL

- Datapath paired with the radix-2 Booth multiplier control unit. It holds operand/accumulator/counter registers and executes the unit's c0..c6 strobes.
- Returns to the control unit the status bits q0, q_1 and count7.
- Sits directly downstream of the control FSM. Presents the 2W-bit signed product on a registered output bus: high half on c5, low half on c6.

---
 rtl/booth_datapath_pkg.sv | 22 ++
 rtl/booth_addsub.sv | 28 ++
 rtl/booth_datapath.sv | 106 ++++++++++
 3 files changed

// File: rtl/booth_datapath_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath: default width,
// control-vector bit positions for the c0..c6 strobes, and the c3 encoding.
package booth_datapath_pkg;

   localparam int W_DEF     = 8;
   localparam int CNT_W_DEF = $clog2(W_DEF);

   localparam int C0_BIT = 0;
   localparam int C1_BIT = 1;
   localparam int C2_BIT = 2;
   localparam int C3_BIT = 3;
   localparam int C4_BIT = 4;
   localparam int C5_BIT = 5;
   localparam int C6_BIT = 6;
   localparam int NUM_CTRL = 7;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

endpackage

// File: rtl/booth_addsub.sv
// N-bit ripple-carry adder/subtractor: s = a + b (sub=0) or a - b (sub=1),
// computed as a + (b ^ {N{sub}}) + sub with the final carry discarded.
module booth_addsub #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] s
);

   logic [N-1:0] b_x;

   assign b_x = b ^ {N{sub}};

   always_comb begin
      logic carry;
      s     = '0;
      carry = sub;
      // NOTE: blocking assignments here are intentional; carry must ripple
      // from bit to bit within a single evaluation of this block.
      for (int i = 0; i < N; i++) begin
         s[i]  = a[i] ^ b_x[i] ^ carry;
         carry = (a[i] & b_x[i]) | (carry & (a[i] ^ b_x[i]));
      end
   end

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: operand, accumulator and counter registers
// driven by the control unit's c0..c6 strobes, with status bits returned to it.
module booth_datapath
   import booth_datapath_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = $clog2(W)
) (
   input  logic           clk,
   input  logic           rst_b,
   input  logic           c0,
   input  logic           c1,
   input  logic           c2,
   input  logic           c3,
   input  logic           c4,
   input  logic           c5,
   input  logic           c6,
   input  logic [W-1:0]   mcand,
   input  logic [W-1:0]   mplier,
   output logic           q0,
   output logic           q_1,
   output logic           count7,
   output logic [W-1:0]   outbus,
   output logic [2*W-1:0] product
);

   logic [NUM_CTRL-1:0] ctrl;
   logic [W:0]          a_q, a_d, sum;
   logic [W-1:0]        q_q, q_d, m_q, m_d, outbus_q, outbus_d;
   logic                qm1_q, qm1_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                do_add, do_shift, sub;

   assign ctrl = {c6, c5, c4, c3, c2, c1, c0};

   // The decision cycle (c1) never lets the datapath move.
   assign do_add   = ctrl[C2_BIT] & ~ctrl[C1_BIT];
   assign do_shift = ctrl[C4_BIT] & ~ctrl[C1_BIT];
   assign sub      = (op_e'(ctrl[C3_BIT]) == OP_SUB);

   // A carries one extra sign bit so -2^(W-1) * -2^(W-1) cannot overflow.
   booth_addsub #(.N(W + 1)) u_addsub (
      .a   (a_q),
      .b   ({m_q[W-1], m_q}),
      .sub (sub),
      .s   (sum)
   );

   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      qm1_d    = qm1_q;
      cnt_d    = cnt_q;
      outbus_d = outbus_q;

      if (ctrl[C0_BIT]) begin
         a_d   = '0;
         q_d   = mplier;
         m_d   = mcand;
         qm1_d = 1'b0;
         cnt_d = '0;
      end else if (do_add) begin
         a_d = sum;
      end else if (do_shift) begin
         {a_d, q_d, qm1_d} = {a_q[W], a_q, q_q};
         cnt_d             = cnt_q + CNT_W'(1);
      end

      // Output bus loads independently of the A/Q/cnt update; low half wins.
      if (ctrl[C6_BIT]) begin
         outbus_d = q_q;
      end else if (ctrl[C5_BIT]) begin
         outbus_d = a_q[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops
      // update together from the values sampled at the edge.
      if (!rst_b) begin
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         qm1_q    <= 1'b0;
         cnt_q    <= '0;
         outbus_q <= '0;
      end else begin
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         qm1_q    <= qm1_d;
         cnt_q    <= cnt_d;
         outbus_q <= outbus_d;
      end
   end

   assign q0      = q_q[0];
   assign q_1     = qm1_q;
   assign count7  = (cnt_q == CNT_W'(W - 1));
   assign outbus  = outbus_q;
   assign product = {a_q[W-1:0], q_q};

endmodule
